// File: rtl/approx_mac_pkg.sv
// Shared types and constants for the approximate MAC accumulator path.
// The APPROX_COMP_BIAS_EN build macro decides whether COMP_BIAS is applied.
package approx_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam logic [15:0] COMP_BIAS = 16'd127;

  // Wide enough that LEN full-scale products plus bias can never wrap.
  function automatic int acc_width(input int prod_w, input int len);
    return prod_w + $clog2(len) + 1;
  endfunction

endpackage

// File: rtl/approx_dot_accum_if.sv
// Product input stream and result output stream of approx_dot_accum.
// Handshake: a beat moves on a rising edge where valid && ready; once raised,
// valid and its payload hold until that edge, and ready never depends on valid.
interface approx_dot_accum_if #(
  parameter int PROD_W = 16,
  parameter int LEN    = 8,
  parameter int ACC_W  = approx_mac_pkg::acc_width(PROD_W, LEN)
);
  localparam int CNT_W = $clog2(LEN) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_cnt;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt
  );
endinterface

// File: rtl/approx_acc_ctrl.sv
// Vector FSM and beat counter: decides when a beat is taken, when the vector
// closes and when the held result is released.
module approx_acc_ctrl
  import approx_mac_pkg::*;
#(
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_in_valid,
  input  logic             i_in_last,
  input  logic             i_out_ready,
  output logic             o_in_ready,
  output logic             o_load,
  output logic             o_first,
  output logic             o_close,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic             o_out_valid,
  output state_e           o_state
);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_accepting;

  // Ready comes from state alone, so no input-to-ready combinational path.
  assign w_accepting = (r_state != ST_HOLD);
  assign w_cnt_next  = (r_state == ST_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);

  assign o_in_ready  = w_accepting;
  assign o_first     = (r_state == ST_IDLE);
  assign o_load      = i_in_valid && w_accepting && !i_clr;
  assign o_close     = o_load && (i_in_last || (w_cnt_next == CNT_W'(LEN)));
  assign o_cnt_next  = w_cnt_next;
  assign o_out_valid = r_out_valid;
  assign o_state     = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else if (i_clr) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (i_in_valid) begin
            r_cnt <= w_cnt_next;
            if (o_close) begin
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/approx_dot_accum.sv
// Sums up to LEN approximate products per vector and presents the dot product.
// Define APPROX_COMP_BIAS_EN to add COMP_BIAS to every product term.
module approx_dot_accum
  import approx_mac_pkg::*;
#(
  parameter int PROD_W = 16,
  parameter int LEN    = 8,
  parameter int ACC_W  = acc_width(PROD_W, LEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  approx_dot_accum_if.slave bus,
  output state_e            o_state
);

  localparam int CNT_W = $clog2(LEN) + 1;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_out_cnt;

  logic             w_in_ready;
  logic             w_load;
  logic             w_first;
  logic             w_close;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_out_valid;
  logic [ACC_W-1:0] w_term;
  logic [ACC_W-1:0] w_acc_next;

  approx_acc_ctrl #(
    .LEN   (LEN),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (clr),
    .i_in_valid  (bus.in_valid),
    .i_in_last   (bus.in_last),
    .i_out_ready (bus.out_ready),
    .o_in_ready  (w_in_ready),
    .o_load      (w_load),
    .o_first     (w_first),
    .o_close     (w_close),
    .o_cnt_next  (w_cnt_next),
    .o_out_valid (w_out_valid),
    .o_state     (o_state)
  );

`ifdef APPROX_COMP_BIAS_EN
  assign w_term = ACC_W'(bus.in_prod) + ACC_W'(COMP_BIAS);
`else
  assign w_term = ACC_W'(bus.in_prod);
`endif

  // A vector's first beat restarts from zero instead of the stale sum.
  assign w_acc_next = (w_first ? '0 : r_acc) + w_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_sum     <= '0;
      r_out_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
    end else if (w_load) begin
      r_acc <= w_acc_next;
      if (w_close) begin
        r_sum     <= w_acc_next;
        r_out_cnt <= w_cnt_next;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_sum   = r_sum;
  assign bus.out_cnt   = r_out_cnt;

endmodule

// File: tb/tb_approx_dot_accum.sv
// Directed bench for approx_dot_accum; expected sums follow APPROX_COMP_BIAS_EN.
module tb_approx_dot_accum;
  import approx_mac_pkg::*;

  localparam int PROD_W = 16;
  localparam int LEN    = 8;
  localparam int ACC_W  = acc_width(PROD_W, LEN);
  localparam int CNT_W  = $clog2(LEN) + 1;
`ifdef APPROX_COMP_BIAS_EN
  localparam int BIAS = 127;
`else
  localparam int BIAS = 0;
`endif

  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   clr = 1'b0;
  state_e dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic [CNT_W-1:0] cnt_q[$];

  approx_dot_accum_if #(.PROD_W(PROD_W), .LEN(LEN), .ACC_W(ACC_W)) bus ();

  approx_dot_accum #(.PROD_W(PROD_W), .LEN(LEN), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // model: each term carries BIAS when compensation is built in
  task automatic push_exp(input int raw_sum, input int cnt);
    exp_q.push_back(ACC_W'(raw_sum + cnt * BIAS));
    cnt_q.push_back(CNT_W'(cnt));
  endtask

  task automatic send_beat(input logic [PROD_W-1:0] p, input logic last);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = p;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("ready_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_prod  = '0;
  endtask

  task automatic collect(input string tag);
    int n = 0;
    logic [ACC_W-1:0] es;
    logic [CNT_W-1:0] ec;
    es = exp_q.pop_front();
    ec = cnt_q.pop_front();
    while (!bus.out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
    check({tag, "_cnt"}, 32'(bus.out_cnt), 32'(ec));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    #12;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum", 32'(bus.out_sum), 32'd0);
    check("rst_cnt", 32'(bus.out_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.in_ready), 32'd1);

    // full-length vector of max products closes on count, no in_last
    for (int i = 0; i < LEN; i++) begin
      send_beat(16'hFFFF, 1'b0);
      if (i == LEN - 2) check("full_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    check("full_latency", 32'(bus.out_valid), 32'd1);
    push_exp(32'h7FFF8, 8);
    collect("full");

    // early termination by in_last
    send_beat(16'd100, 1'b0);
    send_beat(16'd200, 1'b0);
    send_beat(16'd300, 1'b1);
    push_exp(600, 3);
    collect("three");

    // single-product vector straight from IDLE
    send_beat(16'd5, 1'b1);
    check("single_state", 32'(dbg_state), 32'(ST_HOLD));
    push_exp(5, 1);
    collect("single");

    // backpressure in HOLD with upstream still offering a beat
    send_beat(16'd10, 1'b0);
    send_beat(16'd20, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'h1234;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_ready", 32'(bus.in_ready), 32'd0);
      check("bp_sum", 32'(bus.out_sum), 32'(30 + 2 * BIAS));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    check("bp_released", 32'(bus.out_valid), 32'd0);
    check("bp_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("bp_ready_back", 32'(bus.in_ready), 32'd1);
    send_beat(16'd1, 1'b0);
    send_beat(16'd2, 1'b1);
    push_exp(3, 2);
    collect("after_bp");

    // clr mid-vector drops the partial sum and the beat in the clr cycle
    for (int i = 0; i < 4; i++) send_beat(16'd1000, 1'b0);
    check("clr_pre_state", 32'(dbg_state), 32'(ST_ACCUM));
    clr          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_prod  = 16'd50;
    bus.in_last  = 1'b1;
    @(posedge clk); #1;
    clr          = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("clr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("clr_valid", 32'(bus.out_valid), 32'd0);
    send_beat(16'd7, 1'b0);
    send_beat(16'd9, 1'b1);
    push_exp(16, 2);
    collect("post_clr");

    // async reset while a result is held
    send_beat(16'd3, 1'b1);
    check("hold_before_rst", 32'(bus.out_valid), 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_sum", 32'(bus.out_sum), 32'd0);
    check("arst_cnt", 32'(bus.out_cnt), 32'd0);
    check("arst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_beat(16'd40000, 1'b0);
    send_beat(16'd40000, 1'b1);
    push_exp(80000, 2);
    collect("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/approx_dot_accum.md
# approx_dot_accum

Streaming accumulator sitting directly downstream of the column-truncated approximate multiplier array. It consumes one 16-bit approximate product per accepted beat and sums a vector of up to LEN products into a widened accumulator. It emits the dot-product result on a valid/ready output port. Optionally, it adds a per-product bias to compensate the mean truncation error of the multiplier.

## Interface
- PROD_W, 16, width of the incoming approximate product
- LEN, 8, maximum products per vector; must be ≥2
- ACC_W, PROD_W+$clog2(LEN)+1 (=20), accumulator and result width
- COMP_BIAS, 16'd127, constant added to each product when compensation is compiled in
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  synchronous abort; drops the partial sum and returns to IDLE
- in_valid  in  1  product beat valid
- in_ready  out  1  block can accept a product this cycle
- in_prod  in  PROD_W  approximate product (z of multiplier)
- in_last  in  1  marks final product of a vector (early termination)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_sum  out  ACC_W  accumulated dot product
- out_cnt  out  $clog2(LEN)+1  number of products in out_sum

## Operation
- FSM states:
  - IDLE: no partial sum.
  - ACCUM: partial sum held, count ≥1.
  - HOLD: result presented on the output.
- Input beat transfers when in_valid && in_ready.
- in_ready = 1 in IDLE/ACCUM, 0 in HOLD.
- Term = zero-extend(in_prod) (+ COMP_BIAS if compiled in), ACC_W wide.
- Accumulate: acc <= (state==IDLE ? 0 : acc) + term; cnt <= (IDLE ? 1 : cnt+1).
- Transitions:
  - IDLE→ACCUM on a beat when not closing.
  - ACCUM→ACCUM on a beat when not closing.
  - A beat closes the vector if in_last=1 or the new count == LEN. On a closing beat, go →HOLD with out_sum/out_cnt loaded from the updated acc/cnt.
  - A closing beat in IDLE (single-product vector) goes IDLE→HOLD directly.
- HOLD: out_valid=1; out_sum/out_cnt stable until out_ready=1. On handshake, go →IDLE.
- Arithmetic is unsigned. ACC_W guarantees no overflow: LEN×(2^PROD_W−1+COMP_BIAS) < 2^ACC_W. Wrap is impossible by construction.
- clr has priority over everything. It forces IDLE, acc=0, cnt=0, out_valid=0. It also drops a HOLD result not yet accepted. A beat presented in the clr cycle is discarded (in_ready still 1, but ignored).
- in_last asserted together with count reaching LEN: a single close, no special case.
- in_prod/in_last are ignored when in_valid=0.

## Timing
- Reset values (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0
  - out_valid=0, out_sum=0, out_cnt=0
  - in_ready=1 after reset release
- Latency: out_valid rises the cycle after the closing beat is accepted (1 cycle).
- Throughput: one product per cycle inside a vector. One bubble cycle per vector minimum (the HOLD cycle), more under backpressure.
- All outputs are registered except in_ready, which is decoded from state only. There is no combinational path from in_valid or out_ready to in_ready.

## Configuration
- APPROX_COMP_BIAS_EN defined: each term includes +COMP_BIAS.
- APPROX_COMP_BIAS_EN undefined: term = in_prod exactly. COMP_BIAS is unused, and ACC_W keeps its default formula.

## Structure
- Package approx_mac_pkg holds:
  - the state enum (ST_IDLE, ST_ACCUM, ST_HOLD);
  - the function acc_width(prod_w, len);
  - the default COMP_BIAS constant.
- One sub-module, approx_acc_ctrl, holds the FSM plus beat counter. It outputs in_ready, load/close strobes and out_valid; the datapath (term formation, acc, output regs) stays in the top module.

## Test plan
- Reset, then 8 beats of in_prod=16'hFFFF with no in_last, bias off → out_sum=20'h7FFF8, out_cnt=8, out_valid the cycle after beat 8.
- Vector of 3 beats (100, 200, 300) with in_last on beat 3 → out_sum=600, out_cnt=3. The same vector with APPROX_COMP_BIAS_EN → 981.
- Single beat in_prod=5 with in_last=1 from IDLE → out_sum=5, out_cnt=1.
- Hold out_ready=0 for 10 cycles after close, with in_valid=1 throughout → in_ready=0, out_sum stable. Release → handshake, then IDLE, and the next vector starts cleanly.
- clr pulse mid-vector (after 4 beats of 1000), then a new 2-beat vector (7, 9, in_last) → out_sum=16, out_cnt=2.
- rst_n asserted during HOLD → out_valid drops asynchronously, and all outputs read 0.
